// File: rtl/csr_regfile_hs.sv
// Clocked CSR register file: byte-strobed write port, one-cycle read with a valid/ready
// response handshake, and error flags for out-of-range register indices.
module csr_regfile_hs #(
   parameter int unsigned              DATA_WIDTH  = 32,
   parameter int unsigned              ADDR_WIDTH  = 6,
   parameter int unsigned              DEPTH       = 64,
   parameter logic [DATA_WIDTH-1:0]    RESET_VALUE = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [ADDR_WIDTH-1:0]       w_addr,
   input  logic [DATA_WIDTH-1:0]       wdata,
   input  logic [DATA_WIDTH/8-1:0]     wstrb,
   input  logic                        csr_write_enable,
   output logic                        w_err,
   input  logic [ADDR_WIDTH-1:0]       r_addr,
   input  logic                        csr_read_enable,
   output logic                        csr_read_ready,
   output logic [DATA_WIDTH-1:0]       rdata,
   output logic                        rvalid,
   input  logic                        rready,
   output logic                        r_err
);

   localparam int unsigned           NumBytes = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [0:0] {StIdle, StResp} state_e;

   state_e                  state_q;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    w_in_range;
   logic                    r_in_range;
   logic                    accept;

   assign w_in_range     = ({1'b0, w_addr} < DepthW);
   assign r_in_range     = ({1'b0, r_addr} < DepthW);
   assign rvalid         = (state_q == StResp);
   assign csr_read_ready = (state_q == StIdle) | (rvalid & rready);
   assign accept         = csr_read_enable & csr_read_ready;

   // Next-state storage doubles as the write-first read source, so a same-cycle
   // write to the read address is seen byte-merged.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (csr_write_enable && (w_addr == i[ADDR_WIDTH-1:0])) begin
            for (int b = 0; b < NumBytes; b++) begin
               if (wstrb[b]) mem_d[i][8*b +: 8] = wdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_addr == i[ADDR_WIDTH-1:0]) rd_word = mem_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VALUE;
         state_q <= StIdle;
         rdata   <= '0;
         r_err   <= 1'b0;
         w_err   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
         w_err <= csr_write_enable & ~w_in_range;
         if (accept) begin
            state_q <= StResp;
            rdata   <= r_in_range ? rd_word : '0;
            r_err   <= ~r_in_range;
         end else if (state_q == StResp && rready) begin
            state_q <= StIdle;
         end
      end
   end

endmodule

// File: tb/tb_csr_regfile_hs.sv
// Directed bench for csr_regfile_hs (DEPTH=48, non-zero reset value) with hand-computed
// expected values.
module tb_csr_regfile_hs;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 6;
   localparam int unsigned DP = 48;
   localparam logic [DW-1:0] RV = 32'h5A5A_0F0F;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] wdata;
   logic [3:0]    wstrb;
   logic          csr_write_enable;
   logic          w_err;
   logic [AW-1:0] r_addr;
   logic          csr_read_enable;
   logic          csr_read_ready;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          rready;
   logic          r_err;

   int n_vec  = 0;
   int n_miss = 0;

   csr_regfile_hs #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .DEPTH       (DP),
      .RESET_VALUE (RV)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .w_addr           (w_addr),
      .wdata            (wdata),
      .wstrb            (wstrb),
      .csr_write_enable (csr_write_enable),
      .w_err            (w_err),
      .r_addr           (r_addr),
      .csr_read_enable  (csr_read_enable),
      .csr_read_ready   (csr_read_ready),
      .rdata            (rdata),
      .rvalid           (rvalid),
      .rready           (rready),
      .r_err            (r_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
      csr_write_enable = 1'b1;
      w_addr = a;
      wdata  = d;
      wstrb  = s;
      step();
      csr_write_enable = 1'b0;
   endtask

   // Single read with rready=1, then one idle cycle so the FSM is back in IDLE.
   task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                         input logic exp_err);
      csr_read_enable = 1'b1;
      r_addr = a;
      rready = 1'b1;
      step();
      csr_read_enable = 1'b0;
      check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
      check({tag, "_rdata"}, rdata, exp);
      check({tag, "_rerr"}, {31'b0, r_err}, {31'b0, exp_err});
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      csr_write_enable = 1'b0;
      csr_read_enable = 1'b0;
      w_addr = '0;
      wdata = '0;
      wstrb = '0;
      r_addr = '0;
      rready = 1'b1;
      step();
      step();
      check("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_rerr", {31'b0, r_err}, 32'd0);
      check("rst_werr", {31'b0, w_err}, 32'd0);
      check("rst_ready", {31'b0, csr_read_ready}, 32'd1);
      rst_n = 1'b1;
      step();

      // 1: streamed reads of every implemented register after reset
      csr_read_enable = 1'b1;
      rready = 1'b1;
      for (int a = 0; a < DP; a++) begin
         r_addr = AW'(a);
         step();
         check("t1_rvalid", {31'b0, rvalid}, 32'd1);
         check("t1_rdata", rdata, RV);
         check("t1_rerr", {31'b0, r_err}, 32'd0);
      end
      csr_read_enable = 1'b0;
      step();
      check("t1_retire", {31'b0, rvalid}, 32'd0);

      // 2: byte-strobed merge, and empty strobe changes nothing
      wr(6'd5, 32'hAABB_CCDD, 4'b1111);
      wr(6'd5, 32'h1122_3344, 4'b0101);
      rd_chk("t2_merge", 6'd5, 32'hAA22_CC44, 1'b0);
      wr(6'd5, 32'hFFFF_FFFF, 4'b0000);
      check("t2_nostrb_werr", {31'b0, w_err}, 32'd0);
      rd_chk("t2_nostrb", 6'd5, 32'hAA22_CC44, 1'b0);

      // 3: write-first on same address, then parallel write/read to different addresses
      csr_write_enable = 1'b1;
      w_addr = 6'd3;
      wdata = 32'h1234_5678;
      wstrb = 4'b1111;
      csr_read_enable = 1'b1;
      r_addr = 6'd3;
      step();
      csr_write_enable = 1'b0;
      csr_read_enable = 1'b0;
      check("t3_rvalid", {31'b0, rvalid}, 32'd1);
      check("t3_wfirst", rdata, 32'h1234_5678);
      step();
      csr_write_enable = 1'b1;
      w_addr = 6'd4;
      wdata = 32'hCAFE_F00D;
      wstrb = 4'b1111;
      csr_read_enable = 1'b1;
      r_addr = 6'd3;
      step();
      csr_write_enable = 1'b0;
      csr_read_enable = 1'b0;
      check("t3_par_rd", rdata, 32'h1234_5678);
      step();
      rd_chk("t3_par_wr", 6'd4, 32'hCAFE_F00D, 1'b0);

      // 4: stalled response stays stable while the source register is overwritten
      wr(6'd7, 32'hDEAD_BEEF, 4'b1111);
      csr_read_enable = 1'b1;
      r_addr = 6'd7;
      rready = 1'b0;
      step();
      r_addr = 6'd8;
      for (int k = 0; k < 4; k++) begin
         check("t4_hold_rdata", rdata, 32'hDEAD_BEEF);
         check("t4_hold_ready", {31'b0, csr_read_ready}, 32'd0);
         check("t4_hold_rvalid", {31'b0, rvalid}, 32'd1);
         csr_write_enable = 1'b1;
         w_addr = 6'd7;
         wdata = 32'h0;
         wstrb = 4'b1111;
         step();
      end
      csr_write_enable = 1'b0;
      check("t4_hold_end", rdata, 32'hDEAD_BEEF);
      csr_read_enable = 1'b0;
      rready = 1'b1;
      #1;
      check("t4_ready_rr", {31'b0, csr_read_ready}, 32'd1);
      step();
      check("t4_retired", {31'b0, rvalid}, 32'd0);
      rd_chk("t4_reread", 6'd7, 32'h0, 1'b0);

      // 5: out-of-range write and read; no aliasing into implemented registers
      wr(6'd50, 32'hFFFF_FFFF, 4'b1111);
      check("t5_werr", {31'b0, w_err}, 32'd1);
      step();
      check("t5_werr_pulse", {31'b0, w_err}, 32'd0);
      rd_chk("t5_oor63", 6'd63, 32'h0, 1'b1);
      rd_chk("t5_oor48", 6'd48, 32'h0, 1'b1);
      rd_chk("t5_last47", 6'd47, RV, 1'b0);
      rd_chk("t5_alias2", 6'd2, RV, 1'b0);
      rd_chk("t5_alias18", 6'd18, RV, 1'b0);

      // 6: back-to-back reads, then reset with a response pending
      wr(6'd0, 32'h0000_0100, 4'b1111);
      wr(6'd1, 32'h0000_0101, 4'b1111);
      wr(6'd2, 32'h0000_0102, 4'b1111);
      csr_read_enable = 1'b1;
      rready = 1'b1;
      for (int a = 0; a < 3; a++) begin
         r_addr = AW'(a);
         step();
         check("t6_b2b_rvalid", {31'b0, rvalid}, 32'd1);
         check("t6_b2b_rdata", rdata, 32'h0000_0100 + DW'(a));
      end
      rready = 1'b0;
      rst_n = 1'b0;
      r_addr = 6'd5;
      csr_write_enable = 1'b1;
      w_addr = 6'd1;
      wdata = 32'h7777_7777;
      wstrb = 4'b1111;
      step();
      csr_write_enable = 1'b0;
      csr_read_enable = 1'b0;
      check("t6_rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("t6_rst_rdata", rdata, 32'd0);
      check("t6_rst_ready", {31'b0, csr_read_ready}, 32'd1);
      rst_n = 1'b1;
      rready = 1'b1;
      step();
      check("t6_post_werr", {31'b0, w_err}, 32'd0);
      rd_chk("t6_post0", 6'd0, RV, 1'b0);
      rd_chk("t6_post1", 6'd1, RV, 1'b0);
      rd_chk("t6_post2", 6'd2, RV, 1'b0);
      rd_chk("t6_post5", 6'd5, RV, 1'b0);
      rd_chk("t6_post7", 6'd7, RV, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/csr_regfile_hs.md
Name: csr_regfile_hs

Overview:
Parametrised, clocked CSR register file that replaces the combinational CSR memory.
- Write port has byte strobes.
- Read port has 1-cycle latency and a valid/ready response handshake, so a consumer can stall.
- Out-of-range accesses are flagged as errors.
- Sits between the AXI CSR decode logic and the block's control/status registers.

Parameters:
DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
ADDR_WIDTH, 6, width of r_addr/w_addr.
DEPTH, 64, number of implemented registers; DEPTH <= 2**ADDR_WIDTH.
RESET_VALUE, 0, value loaded into every register at reset (DATA_WIDTH bits).

Ports:
clk  input  1  single clock; all logic on its rising edge.
rst_n  input  1  synchronous, active-low reset.
w_addr  input  ADDR_WIDTH  write register index.
wdata  input  DATA_WIDTH  write data.
wstrb  input  DATA_WIDTH/8  byte write enables; bit i covers wdata[8i+7:8i].
csr_write_enable  input  1  write request; always accepted.
w_err  output  1  one-cycle pulse: previous-cycle write was out of range.
r_addr  input  ADDR_WIDTH  read register index.
csr_read_enable  input  1  read request.
csr_read_ready  output  1  read request accepted this cycle when high together with csr_read_enable.
rdata  output  DATA_WIDTH  read response data.
rvalid  output  1  read response valid.
rready  input  1  consumer accepts the response.
r_err  output  1  response error flag, qualified by rvalid.

Behaviour:
- Reset: sampled at posedge with rst_n=0.
  - All DEPTH registers <= RESET_VALUE.
  - rdata=0, rvalid=0, r_err=0, w_err=0, FSM=IDLE.
  - Takes priority over any same-cycle request.
  - Reset mid-response drops the pending response: rvalid=0 the next cycle.
- Write, at posedge with csr_write_enable=1:
  - w_addr<DEPTH: each byte with wstrb[i]=1 is replaced; other bytes are kept.
  - w_addr>=DEPTH: no storage change; w_err=1 for exactly the next cycle.
  - wstrb=0 in range: no change, no error.
  - Writes never stall and are independent of read FSM state.
- Read FSM, states IDLE and RESP:
  - csr_read_ready = (state==IDLE) | (rvalid & rready). Combinational, allows back-to-back reads.
  - accept = csr_read_enable & csr_read_ready.
  - IDLE: accept -> RESP; otherwise stay.
  - RESP: accept -> RESP with new data; rready & !accept -> IDLE; !rready -> hold.
  - rvalid = (state==RESP).
- Latency: accepted read at edge N gives rvalid=1 with data after edge N. Throughput is 1 read/cycle while rready=1.
- Read data:
  - r_addr<DEPTH: rdata = register contents including any same-cycle write to the same address (write-first, byte-merged); r_err=0.
  - r_addr>=DEPTH: rdata=0, r_err=1.
- Hold: while rvalid=1 and rready=0, rdata and r_err stay stable. Later writes to the same register do not alter the held response.
- Simultaneous read and write to different addresses: both complete in the same cycle.
- Addresses are never wrapped or truncated; index compare is against DEPTH.

Test Plan:
1. Reset then read every address 0..DEPTH-1 with rready=1 -> rvalid one cycle after each accept; rdata=RESET_VALUE, r_err=0; 0 returned when RESET_VALUE=0.
2. Write 0xAABBCCDD, wstrb=4'b1111, to addr 5; then write 0x11223344, wstrb=4'b0101, to addr 5; then read addr 5 -> rdata=0xAA22CC44.
3. Same cycle: write 0x12345678, full strobes, to addr 3 and read addr 3 -> next cycle rvalid=1, rdata=0x12345678 (write-first).
4. Read addr 7 holding 0xDEADBEEF with rready=0 for 4 cycles, writing 0 to addr 7 meanwhile -> rdata stays 0xDEADBEEF, csr_read_ready=0, rvalid=1. Raise rready -> response retires; next read of addr 7 returns 0.
5. With DEPTH=48, write addr 50 then read addr 63 -> w_err=1 for one cycle with no register changed; then rvalid=1, r_err=1, rdata=0.
6. Back-to-back reads of addr 0,1,2 with rready=1, then assert rst_n=0 while a response is pending -> three consecutive valid responses; after reset, rvalid=0 and all registers=RESET_VALUE.
